// File: rtl/kappa3_dbg_ctrl.sv
// kappa3-light debug/run-control responder: host strobes to load pulses, phase enables, memory access.
// Optional breakpoint unit enabled with `define DBG_BREAKPOINT_EN.
module kappa3_dbg_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int XLEN    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            step_phase,
    input  logic            step_inst,
    input  logic            halt,
    input  logic            inst_end,
    output logic            phase_adv,
    output logic            running,
    input  logic [XLEN-1:0] dbg_in,
    input  logic            dbg_pc_ld,
    input  logic            dbg_ir_ld,
    input  logic            dbg_reg_ld,
    input  logic            dbg_a_ld,
    input  logic            dbg_b_ld,
    input  logic            dbg_c_ld,
    input  logic [4:0]      dbg_reg_addr,
    input  logic [XLEN-1:0] dbg_mem_addr,
    input  logic            dbg_mem_read,
    input  logic            dbg_mem_write,
    output logic [XLEN-1:0] dbg_mem_out,
    output logic            pc_ld,
    output logic            ir_ld,
    output logic            reg_ld,
    output logic            a_ld,
    output logic            b_ld,
    output logic            c_ld,
    output logic [4:0]      reg_addr,
    output logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
`ifdef DBG_BREAKPOINT_EN
    input  logic            dbg_bp_ld,
    input  logic [XLEN-1:0] pc_next,
    output logic            bp_hit,
`endif
    output logic            dbg_busy,
    output logic            dbg_err
);

    typedef enum logic [1:0] {R_IDLE, R_RUN, R_STEP, R_INST} run_t;
    typedef enum logic [1:0] {M_IDLE, M_RD, M_WAIT, M_WR} mem_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

`ifdef DBG_BREAKPOINT_EN
    localparam int NS = 12;
`else
    localparam int NS = 11;
`endif

    logic [NS-1:0] raw;
    logic [NS-1:0] raw_q;
    logic [NS-1:0] ev;

`ifdef DBG_BREAKPOINT_EN
    assign raw = {dbg_bp_ld, dbg_mem_write, dbg_mem_read,
                  dbg_c_ld, dbg_b_ld, dbg_a_ld, dbg_reg_ld,
                  dbg_ir_ld, dbg_pc_ld, step_inst, step_phase, run};
`else
    assign raw = {dbg_mem_write, dbg_mem_read,
                  dbg_c_ld, dbg_b_ld, dbg_a_ld, dbg_reg_ld,
                  dbg_ir_ld, dbg_pc_ld, step_inst, step_phase, run};
`endif

    assign ev = raw & ~raw_q;

    logic ev_run, ev_sp, ev_si;
    logic ev_pc, ev_ir, ev_reg, ev_a, ev_b, ev_c;
    logic ev_mr, ev_mw;

    assign ev_run = ev[0];
    assign ev_sp  = ev[1];
    assign ev_si  = ev[2];
    assign ev_pc  = ev[3];
    assign ev_ir  = ev[4];
    assign ev_reg = ev[5];
    assign ev_a   = ev[6];
    assign ev_b   = ev[7];
    assign ev_c   = ev[8];
    assign ev_mr  = ev[9];
    assign ev_mw  = ev[10];

    run_t       run_st, run_nx;
    mem_t       mem_st, mem_nx;
    logic [3:0] cnt;
    logic       cap;
    logic       bp_set;
    logic       ld_any;
    logic       ld_go;
    logic       mem_any;
    logic       wr_go;
    logic       rd_go;
    logic       err_set;

`ifdef DBG_BREAKPOINT_EN
    logic            ev_bp;
    logic [XLEN-1:0] bp_addr;
    logic            bp_valid;
    logic            bp_match;

    assign ev_bp    = ev[11];
    assign bp_match = bp_valid && (pc_next == bp_addr);
    assign ld_any   = ev_pc | ev_ir | ev_reg | ev_a | ev_b | ev_c | ev_bp;
`else
    assign ld_any   = ev_pc | ev_ir | ev_reg | ev_a | ev_b | ev_c;
`endif

    assign running  = (run_st != R_IDLE);
    assign dbg_busy = (mem_st != M_IDLE);
    assign mem_any  = ev_mr | ev_mw;
    assign ld_go    = (ev_pc | ev_ir | ev_reg | ev_a | ev_b | ev_c) & ~running;
    assign wr_go    = ev_mw & ~running & ~dbg_busy;
    assign rd_go    = ev_mr & ~ev_mw & ~running & ~dbg_busy;

    // Anything dropped for bus ownership, a busy port or a read/write collision.
    assign err_set = (running & (ld_any | mem_any))
                   | (~running & dbg_busy & mem_any)
                   | (~running & ~dbg_busy & ev_mr & ev_mw);

    assign mem_wdata = ld_data;

    always_comb begin
        run_nx    = run_st;
        phase_adv = 1'b0;
        bp_set    = 1'b0;
        unique case (run_st)
            R_IDLE: begin
                if (ev_run) begin
                    run_nx = R_RUN;
                end else if (ev_sp) begin
                    run_nx = R_STEP;
                end else if (ev_si) begin
                    run_nx = R_INST;
                end
            end
            R_RUN: begin
                if (halt || ev_run) begin
                    run_nx = R_IDLE;
                end else begin
                    phase_adv = 1'b1;
`ifdef DBG_BREAKPOINT_EN
                    if (inst_end && bp_match) begin
                        run_nx = R_IDLE;
                        bp_set = 1'b1;
                    end
`endif
                end
            end
            R_STEP: begin
                phase_adv = 1'b1;
                run_nx    = R_IDLE;
            end
            R_INST: begin
                phase_adv = 1'b1;
                if (inst_end) begin
                    run_nx = R_IDLE;
                end
            end
            default: run_nx = R_IDLE;
        endcase
    end

    always_comb begin
        mem_nx = mem_st;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        cap    = 1'b0;
        unique case (mem_st)
            M_IDLE: begin
                if (wr_go) begin
                    mem_nx = M_WR;
                end else if (rd_go) begin
                    mem_nx = M_RD;
                end
            end
            M_WR: begin
                mem_wr = 1'b1;
                mem_nx = M_IDLE;
            end
            M_RD: begin
                mem_rd = 1'b1;
                mem_nx = M_WAIT;
            end
            M_WAIT: begin
                if (cnt == 4'd0) begin
                    cap    = 1'b1;
                    mem_nx = M_IDLE;
                end
            end
            default: mem_nx = M_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            run_st <= R_IDLE;
            mem_st <= M_IDLE;
            raw_q  <= '0;
        end else begin
            run_st <= run_nx;
            mem_st <= mem_nx;
            raw_q  <= raw;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_ld       <= 1'b0;
            ir_ld       <= 1'b0;
            reg_ld      <= 1'b0;
            a_ld        <= 1'b0;
            b_ld        <= 1'b0;
            c_ld        <= 1'b0;
            reg_addr    <= '0;
            ld_data     <= '0;
            mem_addr    <= '0;
            dbg_mem_out <= '0;
            dbg_err     <= 1'b0;
            cnt         <= '0;
        end else begin
            pc_ld  <= ev_pc & ~running;
            ir_ld  <= ev_ir & ~running;
            reg_ld <= ev_reg & ~running;
            a_ld   <= ev_a & ~running;
            b_ld   <= ev_b & ~running;
            c_ld   <= ev_c & ~running;
            if (ld_go || wr_go) begin
                ld_data <= dbg_in;
            end
            if (ev_reg && !running) begin
                reg_addr <= dbg_reg_addr;
            end
            if (wr_go || rd_go) begin
                mem_addr <= dbg_mem_addr & ~XLEN'(3);
            end
            if (cap) begin
                dbg_mem_out <= mem_rdata;
            end
            if (err_set) begin
                dbg_err <= 1'b1;
            end
            // Latency countdown: load on the pulse, capture when it reaches zero.
            if (mem_st == M_RD) begin
                cnt <= LAT_LAST;
            end else if (mem_st == M_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef DBG_BREAKPOINT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            bp_addr  <= '0;
            bp_valid <= 1'b0;
            bp_hit   <= 1'b0;
        end else begin
            if (ev_bp && !running) begin
                bp_addr  <= dbg_in;
                bp_valid <= 1'b1;
            end
            if (bp_set) begin
                bp_hit <= 1'b1;
            end else if (ev_run) begin
                bp_hit <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kappa3_dbg_ctrl.sv
// Directed self-checking bench for kappa3_dbg_ctrl (MEM_LAT=3).
// Breakpoint scenario runs only when DBG_BREAKPOINT_EN is defined.
module tb_kappa3_dbg_ctrl;

    localparam int MEM_LAT = 3;
    localparam int XLEN    = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b0;
    logic            step_phase = 1'b0;
    logic            step_inst = 1'b0;
    logic            halt = 1'b0;
    logic            inst_end = 1'b0;
    logic            phase_adv;
    logic            running;
    logic [XLEN-1:0] dbg_in = '0;
    logic            dbg_pc_ld = 1'b0;
    logic            dbg_ir_ld = 1'b0;
    logic            dbg_reg_ld = 1'b0;
    logic            dbg_a_ld = 1'b0;
    logic            dbg_b_ld = 1'b0;
    logic            dbg_c_ld = 1'b0;
    logic [4:0]      dbg_reg_addr = '0;
    logic [XLEN-1:0] dbg_mem_addr = '0;
    logic            dbg_mem_read = 1'b0;
    logic            dbg_mem_write = 1'b0;
    logic [XLEN-1:0] dbg_mem_out;
    logic            pc_ld, ir_ld, reg_ld, a_ld, b_ld, c_ld;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rd, mem_wr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            dbg_busy;
    logic            dbg_err;
`ifdef DBG_BREAKPOINT_EN
    logic            dbg_bp_ld = 1'b0;
    logic [XLEN-1:0] pc_next = '0;
    logic            bp_hit;
`endif

    int vec  = 0;
    int miss = 0;

    kappa3_dbg_ctrl #(.MEM_LAT(MEM_LAT), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .run(run),
        .step_phase(step_phase), .step_inst(step_inst),
        .halt(halt), .inst_end(inst_end),
        .phase_adv(phase_adv), .running(running),
        .dbg_in(dbg_in), .dbg_pc_ld(dbg_pc_ld), .dbg_ir_ld(dbg_ir_ld),
        .dbg_reg_ld(dbg_reg_ld), .dbg_a_ld(dbg_a_ld),
        .dbg_b_ld(dbg_b_ld), .dbg_c_ld(dbg_c_ld),
        .dbg_reg_addr(dbg_reg_addr), .dbg_mem_addr(dbg_mem_addr),
        .dbg_mem_read(dbg_mem_read), .dbg_mem_write(dbg_mem_write),
        .dbg_mem_out(dbg_mem_out),
        .pc_ld(pc_ld), .ir_ld(ir_ld), .reg_ld(reg_ld),
        .a_ld(a_ld), .b_ld(b_ld), .c_ld(c_ld),
        .reg_addr(reg_addr), .ld_data(ld_data), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
`ifdef DBG_BREAKPOINT_EN
        .dbg_bp_ld(dbg_bp_ld), .pc_next(pc_next), .bp_hit(bp_hit),
`endif
        .dbg_busy(dbg_busy), .dbg_err(dbg_err)
    );

    always #5 clock = ~clock;

    // Memory model: data appears MEM_LAT cycles after the mem_rd pulse.
    logic [31:0] mem_m [0:15];
    logic [3:0]  ra = '0;
    int          k = 0;

    always @(posedge clock) begin
        if (mem_wr) mem_m[mem_addr[5:2]] <= mem_wdata;
        if (mem_rd) begin
            k  <= 1;
            ra <= mem_addr[5:2];
        end else if (k != 0 && k < MEM_LAT) begin
            k <= k + 1;
        end else begin
            k <= 0;
        end
    end

    assign mem_rdata = (k == MEM_LAT) ? mem_m[ra] : 32'hBAD0BAD0;

    int pa_n = 0, pc_n = 0, rd_n = 0, wr_n = 0, busy_n = 0, reg_n = 0;

    always @(negedge clock) begin
        if (phase_adv) pa_n <= pa_n + 1;
        if (pc_ld) pc_n <= pc_n + 1;
        if (mem_rd) rd_n <= rd_n + 1;
        if (mem_wr) wr_n <= wr_n + 1;
        if (dbg_busy) busy_n <= busy_n + 1;
        if (reg_ld) reg_n <= reg_n + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        vec++;
        if ({pc_ld, ir_ld, reg_ld, a_ld, b_ld, c_ld, mem_rd, mem_wr,
             dbg_busy, dbg_err, running, phase_adv} !== 12'h000) begin
            miss++;
            $display("FAIL reset_ctl got=%b want=0", {pc_ld, ir_ld, reg_ld,
                     a_ld, b_ld, c_ld, mem_rd, mem_wr, dbg_busy, dbg_err,
                     running, phase_adv});
        end
        vec++;
        if ({ld_data, mem_addr, dbg_mem_out, reg_addr} !== '0) begin
            miss++;
            $display("FAIL reset_data ld=%h ma=%h mo=%h ra=%h want=0",
                     ld_data, mem_addr, dbg_mem_out, reg_addr);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reg_load;
        int p0;
        p0 = pc_n;
        dbg_in = 32'h10000000;
        dbg_pc_ld = 1'b1;
        tick;
        vec++;
        if (pc_ld !== 1'b1 || ld_data !== 32'h10000000) begin
            miss++;
            $display("FAIL pc_pulse pc_ld=%b ld_data=%h want 1/10000000",
                     pc_ld, ld_data);
        end
        tick;
        vec++;
        if (pc_ld !== 1'b0) begin
            miss++;
            $display("FAIL pc_width pc_ld=%b want 0", pc_ld);
        end
        tick;
        tick;
        dbg_pc_ld = 1'b0;
        tick;
        vec++;
        if (pc_n - p0 !== 1) begin
            miss++;
            $display("FAIL pc_count got=%0d want=1", pc_n - p0);
        end
        dbg_in = 32'hA5A50F0F;
        dbg_reg_addr = 5'd17;
        {dbg_reg_ld, dbg_a_ld, dbg_b_ld, dbg_c_ld} = 4'hF;
        tick;
        vec++;
        if ({reg_ld, a_ld, b_ld, c_ld, pc_ld, ir_ld} !== 6'b111100 ||
            ld_data !== 32'hA5A50F0F || reg_addr !== 5'd17) begin
            miss++;
            $display("FAIL par_load pulses=%b ld=%h ra=%0d want 111100/a5a50f0f/17",
                     {reg_ld, a_ld, b_ld, c_ld, pc_ld, ir_ld}, ld_data, reg_addr);
        end
        {dbg_reg_ld, dbg_a_ld, dbg_b_ld, dbg_c_ld} = 4'h0;
        dbg_in = 32'h0;
        dbg_reg_addr = 5'd3;
        tick;
        tick;
        vec++;
        if ({reg_ld, a_ld, b_ld, c_ld} !== 4'h0 ||
            ld_data !== 32'hA5A50F0F || reg_addr !== 5'd17) begin
            miss++;
            $display("FAIL load_hold pulses=%b ld=%h ra=%0d want 0/a5a50f0f/17",
                     {reg_ld, a_ld, b_ld, c_ld}, ld_data, reg_addr);
        end
    endtask

    task automatic test_mem;
        int b0, r0, w0;
        w0 = wr_n;
        dbg_mem_addr = 32'h10000006;
        dbg_in = 32'hDEADBEEF;
        dbg_mem_write = 1'b1;
        tick;
        vec++;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h10000004 ||
            mem_wdata !== 32'hDEADBEEF || dbg_busy !== 1'b1) begin
            miss++;
            $display("FAIL mem_write wr=%b a=%h d=%h busy=%b want 1/10000004/deadbeef/1",
                     mem_wr, mem_addr, mem_wdata, dbg_busy);
        end
        dbg_mem_write = 1'b0;
        tick;
        tick;
        vec++;
        if (wr_n - w0 !== 1 || dbg_busy !== 1'b0) begin
            miss++;
            $display("FAIL write_count got=%0d busy=%b want 1/0", wr_n - w0, dbg_busy);
        end
        b0 = busy_n;
        r0 = rd_n;
        dbg_mem_read = 1'b1;
        tick;
        vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h10000004) begin
            miss++;
            $display("FAIL mem_read rd=%b a=%h want 1/10000004", mem_rd, mem_addr);
        end
        dbg_mem_read = 1'b0;
        repeat (7) tick;
        vec++;
        if (busy_n - b0 !== 4 || rd_n - r0 !== 1) begin
            miss++;
            $display("FAIL busy_len busy=%0d rd=%0d want 4/1", busy_n - b0, rd_n - r0);
        end
        vec++;
        if (dbg_mem_out !== 32'hDEADBEEF || dbg_err !== 1'b0) begin
            miss++;
            $display("FAIL read_data got=%h err=%b want deadbeef/0", dbg_mem_out, dbg_err);
        end
    endtask

    task automatic test_step;
        int p0;
        p0 = pa_n;
        step_inst = 1'b1;
        tick;
        tick;
        tick;
        tick;
        inst_end = 1'b1;
        vec++;
        if (running !== 1'b1 || phase_adv !== 1'b1) begin
            miss++;
            $display("FAIL step_inst_run run=%b pa=%b want 1/1", running, phase_adv);
        end
        tick;
        inst_end = 1'b0;
        vec++;
        if (running !== 1'b0 || phase_adv !== 1'b0 || pa_n - p0 !== 4) begin
            miss++;
            $display("FAIL step_inst_end run=%b pa=%b n=%0d want 0/0/4",
                     running, phase_adv, pa_n - p0);
        end
        step_inst = 1'b0;
        tick;
        p0 = pa_n;
        step_phase = 1'b1;
        tick;
        vec++;
        if (phase_adv !== 1'b1 || running !== 1'b1) begin
            miss++;
            $display("FAIL step_phase pa=%b run=%b want 1/1", phase_adv, running);
        end
        tick;
        tick;
        step_phase = 1'b0;
        tick;
        vec++;
        if (pa_n - p0 !== 1 || running !== 1'b0) begin
            miss++;
            $display("FAIL step_phase_cnt n=%0d run=%b want 1/0", pa_n - p0, running);
        end
    endtask

    task automatic test_run;
        int p0, r0;
        p0 = pa_n;
        r0 = reg_n;
        run = 1'b1;
        tick;
        run = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step_phase = (i == 20);
            dbg_reg_ld = (i == 50);
            if (i == 25) begin
                vec++;
                if (dbg_err !== 1'b0 || running !== 1'b1) begin
                    miss++;
                    $display("FAIL step_in_run err=%b run=%b want 0/1", dbg_err, running);
                end
            end
            tick;
        end
        step_phase = 1'b0;
        dbg_reg_ld = 1'b0;
        halt = 1'b1;
        #1;
        vec++;
        if (phase_adv !== 1'b0 || running !== 1'b1) begin
            miss++;
            $display("FAIL halt_cycle pa=%b run=%b want 0/1", phase_adv, running);
        end
        tick;
        halt = 1'b0;
        vec++;
        if (running !== 1'b0) begin
            miss++;
            $display("FAIL halt_stop run=%b want 0", running);
        end
        tick;
        vec++;
        if (pa_n - p0 !== 100 || reg_n - r0 !== 0 || dbg_err !== 1'b1) begin
            miss++;
            $display("FAIL run_owner pa=%0d reg=%0d err=%b want 100/0/1",
                     pa_n - p0, reg_n - r0, dbg_err);
        end
    endtask

    task automatic test_collision;
        int w0;
        do_reset;
        w0 = wr_n;
        dbg_mem_addr = 32'h10000004;
        dbg_in = 32'h55555555;
        dbg_mem_read = 1'b1;
        tick;
        dbg_mem_read = 1'b0;
        dbg_mem_write = 1'b1;
        tick;
        dbg_mem_write = 1'b0;
        repeat (6) tick;
        vec++;
        if (wr_n - w0 !== 0 || dbg_err !== 1'b1 ||
            dbg_mem_out !== 32'hDEADBEEF) begin
            miss++;
            $display("FAIL busy_drop wr=%0d err=%b out=%h want 0/1/deadbeef",
                     wr_n - w0, dbg_err, dbg_mem_out);
        end
    endtask

    task automatic test_simul;
        int r0;
        do_reset;
        r0 = rd_n;
        dbg_mem_addr = 32'h1000000B;
        dbg_in = 32'h12345678;
        dbg_mem_read = 1'b1;
        dbg_mem_write = 1'b1;
        tick;
        vec++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h10000008) begin
            miss++;
            $display("FAIL wr_wins wr=%b rd=%b a=%h want 1/0/10000008",
                     mem_wr, mem_rd, mem_addr);
        end
        dbg_mem_read = 1'b0;
        dbg_mem_write = 1'b0;
        repeat (6) tick;
        vec++;
        if (rd_n - r0 !== 0 || dbg_err !== 1'b1) begin
            miss++;
            $display("FAIL rd_drop rd=%0d err=%b want 0/1", rd_n - r0, dbg_err);
        end
    endtask

    task automatic test_reset_mid;
        int r0, w0;
        r0 = rd_n;
        w0 = wr_n;
        dbg_mem_addr = 32'h10000004;
        dbg_mem_read = 1'b1;
        tick;
        dbg_mem_read = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        repeat (6) tick;
        vec++;
        if (rd_n - r0 !== 1 || wr_n - w0 !== 0 || dbg_busy !== 1'b0 ||
            dbg_mem_out !== 32'h0 || dbg_err !== 1'b0) begin
            miss++;
            $display("FAIL reset_mid rd=%0d wr=%0d busy=%b out=%h err=%b want 1/0/0/0/0",
                     rd_n - r0, wr_n - w0, dbg_busy, dbg_mem_out, dbg_err);
        end
    endtask

`ifdef DBG_BREAKPOINT_EN
    task automatic test_breakpoint;
        int p0;
        do_reset;
        dbg_in = 32'h10000008;
        dbg_bp_ld = 1'b1;
        tick;
        dbg_bp_ld = 1'b0;
        inst_end = 1'b1;
        pc_next = 32'h10000000;
        p0 = pa_n;
        run = 1'b1;
        tick;
        run = 1'b0;
        tick;
        pc_next = 32'h10000004;
        tick;
        pc_next = 32'h10000008;
        tick;
        vec++;
        if (running !== 1'b0 || bp_hit !== 1'b1 || pa_n - p0 !== 3) begin
            miss++;
            $display("FAIL bp_stop run=%b hit=%b pa=%0d want 0/1/3",
                     running, bp_hit, pa_n - p0);
        end
        inst_end = 1'b0;
        run = 1'b1;
        tick;
        run = 1'b0;
        vec++;
        if (bp_hit !== 1'b0 || running !== 1'b1) begin
            miss++;
            $display("FAIL bp_clear hit=%b run=%b want 0/1", bp_hit, running);
        end
        tick;
        run = 1'b1;
        tick;
        run = 1'b0;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_reg_load;
        test_mem;
        test_step;
        test_run;
        test_collision;
        test_simul;
        test_reset_mid;
`ifdef DBG_BREAKPOINT_EN
        test_breakpoint;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
